divisor_arbitro_rr: RTL and testbench
=====================================

// Module: divisor_arbitro_rr
// PURPOSE
// - Round-robin arbiter/sequencer sharing one Divisor_Algoritmico instance among N_REQ requesters.
// - Grants one request at a time and latches its operands.
// - Pulses the divider Start, waits for Done, then returns Coc/Res tagged with the requester id.
// - Sits between client blocks and the single divider datapath; the divider is never overlapped.
// PARAMETERS
// - tamanyo  32  operand/result width; must match the divider instance.
// - N_REQ    4   number of requesters, >=2; ID_W = $clog2(N_REQ).
// PORTS
// - CLK        in   1               clock; all logic on rising edge.
// - RSTa       in   1               asynchronous, active-low reset; same net as the divider reset.
// - Req        in   N_REQ           per-requester request level; held with operands until granted.
// - Num_in     in   N_REQ*tamanyo   packed [N_REQ-1:0][tamanyo-1:0] dividends.
// - Den_in     in   N_REQ*tamanyo   packed divisors.
// - Gnt        out  N_REQ           one-hot, 1-cycle pulse; operands captured this cycle.
// - Rsp_valid  out  1               result valid; held until Rsp_ack.
// - Rsp_id     out  ID_W            index of the requester owning the result.
// - Rsp_Coc    out  tamanyo         quotient.
// - Rsp_Res    out  tamanyo         remainder.
// - Rsp_ack    in   1               result consumed; sampled only while Rsp_valid=1.
// - Div_Zero   out  1               divide-by-zero flag, qualified by Rsp_valid; tied 0 without the macro.
// - Busy       out  1               1 whenever state != IDLE.
// - Div_Start  out  1               divider Start, 1-cycle pulse.
// - Div_Num    out  tamanyo         divider Num; stable from Div_Start through Div_Done.
// - Div_Den    out  tamanyo         divider Den; stable from Div_Start through Div_Done.
// - Div_Coc    in   tamanyo         divider Coc.
// - Div_Res    in   tamanyo         divider Res.
// - Div_Done   in   1               divider Done pulse.
// BEHAVIOUR
// - Reset: all outputs 0; state IDLE; RR pointer=0, so requester 0 has top priority.
// - Reset may assert at any time and aborts any operation; no result is delivered.
// - FSM IDLE: if any Req, pick the first set bit searching from ptr upward, wrapping modulo N_REQ.
//   - Register Gnt[k]=1, Num/Den[k] into Div_Num/Div_Den, id=k, ptr<=k+1 (wraps N_REQ-1->0).
//   - Go to ISSUE. With no Req, stay in IDLE.
// - ISSUE: Div_Start=1 for exactly this cycle, Gnt pulse visible this cycle; go to WAIT.
//   - Req[k] may drop from the next cycle onward.
// - WAIT: hold Div_Num/Div_Den. On Div_Done=1, latch Div_Coc/Div_Res into Rsp_Coc/Rsp_Res and go to RESP.
//   - No timeout.
// - RESP: Rsp_valid=1; Rsp_id, Rsp_Coc, Rsp_Res, Div_Zero stable.
//   - On Rsp_ack=1, Rsp_valid=0 next cycle and go to IDLE.
//   - Ack in the first RESP cycle is legal.
// - Minimum period between consecutive grants: 3 cycles plus divider latency, because IDLE is always one cycle.
// - Div_Done is ignored outside WAIT. Rsp_ack is ignored outside RESP.
// - Req changes during Busy do not affect the current op; they are re-evaluated in IDLE.
// - Operands and results pass through bit-exact; the arbiter does no signed interpretation.
// - Rsp_Coc/Rsp_Res keep their last value after ack and are 0 after reset.
// CONFIGURATION
// - Macro DIV_ZERO_CHECK_EN.
// - Defined: in IDLE, a granted request with Den==0 still pulses Gnt but skips ISSUE/WAIT.
//   - Div_Start is not pulsed.
//   - Next cycle enters RESP with Rsp_Coc='1 (all ones), Rsp_Res=Num, Div_Zero=1.
//   - Div_Zero=0 for every divider-computed result.
// - Undefined: Den==0 is issued to the divider like any other operand; Div_Zero is tied 0.
// TESTING
// - Reset, then Req=0001, Num0=100, Den0=7.
//   -> Gnt=0001 once, Div_Start once, after Done: Rsp_valid, id=0, Coc=14, Res=2.
// - Req=1111 held, immediate ack.
//   -> grant order 0,1,2,3,0; exactly one Div_Start per grant; no Start while Busy.
// - Num=-7 (0xFFFFFFF9), Den=2.
//   -> Rsp_Coc=0xFFFFFFFD, Rsp_Res=0xFFFFFFFF, passed unchanged from the divider.
// - Rsp_ack held 0 for 10 cycles with Req=0010 pending.
//   -> Rsp_valid and data stable, no new Gnt until ack, then Gnt=0010.
// - RSTa=0 mid-WAIT, then release with Req=0100.
//   -> outputs 0, no Rsp_valid for the aborted op; first grant=0100 with ptr restarted at 0.
// - DIV_ZERO_CHECK_EN, Num=55, Den=0.
//   -> no Div_Start; Rsp_valid 2 cycles after Req; Coc=0xFFFFFFFF, Res=55, Div_Zero=1.
//   -> Without the macro, Div_Start is pulsed and Div_Zero=0.

Source files
------------

// File: rtl/divisor_arbitro_rr.sv
// Round-robin arbiter that shares a single Divisor_Algoritmico among N_REQ requesters.
// Optional macro DIV_ZERO_CHECK_EN answers Den==0 locally instead of issuing it to the divider.
module divisor_arbitro_rr #(
  parameter int tamanyo = 32,
  parameter int N_REQ   = 4,
  localparam int ID_W   = $clog2(N_REQ)
) (
  input  logic                       CLK,
  input  logic                       RSTa,
  input  logic [N_REQ-1:0]           Req,
  input  logic [N_REQ*tamanyo-1:0]   Num_in,
  input  logic [N_REQ*tamanyo-1:0]   Den_in,
  output logic [N_REQ-1:0]           Gnt,
  output logic                       Rsp_valid,
  output logic [ID_W-1:0]            Rsp_id,
  output logic [tamanyo-1:0]         Rsp_Coc,
  output logic [tamanyo-1:0]         Rsp_Res,
  input  logic                       Rsp_ack,
  output logic                       Div_Zero,
  output logic                       Busy,
  output logic                       Div_Start,
  output logic [tamanyo-1:0]         Div_Num,
  output logic [tamanyo-1:0]         Div_Den,
  input  logic [tamanyo-1:0]         Div_Coc,
  input  logic [tamanyo-1:0]         Div_Res,
  input  logic                       Div_Done,
  output logic [1:0]                 dbg_state
);

  // Handshakes: Req is a level held with its operands until the one-cycle Gnt pulse;
  // Rsp_valid is held until the cycle Rsp_ack=1 is sampled, and drops on the next edge.

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t             state, state_nx;
  logic [ID_W-1:0]    ptr, pick, ptr_nx;
  logic               found;
  logic [tamanyo-1:0] num_sel, den_sel;
  logic               zero_sel;
  logic               zero_r;

  // First set request starting at ptr and wrapping modulo N_REQ.
  always_comb begin
    int j;
    logic [ID_W-1:0] jj;
    found   = 1'b0;
    pick    = '0;
    num_sel = '0;
    den_sel = '0;
    j       = 0;
    jj      = '0;
    for (int i = 0; i < N_REQ; i++) begin
      j = int'(ptr) + i;
      if (j >= N_REQ) j = j - N_REQ;
      jj = ID_W'(j);
      if (!found && Req[jj]) begin
        found   = 1'b1;
        pick    = jj;
        num_sel = Num_in[j*tamanyo +: tamanyo];
        den_sel = Den_in[j*tamanyo +: tamanyo];
      end
    end
  end

  assign ptr_nx = (pick == ID_W'(N_REQ-1)) ? '0 : pick + 1'b1;

`ifdef DIV_ZERO_CHECK_EN
  assign zero_sel = (den_sel == '0);
  assign Div_Zero = zero_r & Rsp_valid;
`else
  assign zero_sel = 1'b0;
  assign Div_Zero = 1'b0;
`endif

  always_ff @(posedge CLK or negedge RSTa) begin
    if (!RSTa) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (found) state_nx = zero_sel ? S_RESP : S_ISSUE;
      S_ISSUE: state_nx = S_WAIT;
      S_WAIT:  if (Div_Done) state_nx = S_RESP;
      S_RESP:  if (Rsp_ack) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  assign Busy      = (state != S_IDLE);
  assign dbg_state = state;

  always_ff @(posedge CLK or negedge RSTa) begin
    if (!RSTa) begin
      Gnt       <= '0;
      Div_Start <= 1'b0;
      Div_Num   <= '0;
      Div_Den   <= '0;
      Rsp_id    <= '0;
      Rsp_Coc   <= '0;
      Rsp_Res   <= '0;
      Rsp_valid <= 1'b0;
      ptr       <= '0;
      zero_r    <= 1'b0;
    end else begin
      Gnt       <= '0;
      Div_Start <= 1'b0;
      case (state)
        S_IDLE: begin
          if (found) begin
            Gnt     <= {{(N_REQ-1){1'b0}}, 1'b1} << pick;
            Div_Num <= num_sel;
            Div_Den <= den_sel;
            Rsp_id  <= pick;
            ptr     <= ptr_nx;
            zero_r  <= zero_sel;
            if (zero_sel) begin
              // Answered locally: quotient saturates, remainder is the dividend.
              Rsp_Coc   <= '1;
              Rsp_Res   <= num_sel;
              Rsp_valid <= 1'b1;
            end else begin
              Div_Start <= 1'b1;
            end
          end
        end
        S_WAIT: begin
          if (Div_Done) begin
            Rsp_Coc   <= Div_Coc;
            Rsp_Res   <= Div_Res;
            Rsp_valid <= 1'b1;
          end
        end
        S_RESP: begin
          if (Rsp_ack) Rsp_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_divisor_arbitro_rr.sv
// Directed bench for divisor_arbitro_rr with a behavioural fixed-latency signed divider.
module tb_divisor_arbitro_rr;
  localparam int W   = 32;
  localparam int N   = 4;
  localparam int LAT = 4;

  logic           CLK = 1'b0;
  logic           RSTa = 1'b0;
  logic [N-1:0]   Req = '0;
  logic [N*W-1:0] Num_in = '0, Den_in = '0;
  logic [N-1:0]   Gnt;
  logic           Rsp_valid;
  logic [1:0]     Rsp_id;
  logic [W-1:0]   Rsp_Coc, Rsp_Res;
  logic           Rsp_ack = 1'b0;
  logic           Div_Zero, Busy, Div_Start;
  logic [W-1:0]   Div_Num, Div_Den;
  logic [W-1:0]   Div_Coc, Div_Res;
  logic           Div_Done;
  logic [1:0]     dbg_state;

  divisor_arbitro_rr #(.tamanyo(W), .N_REQ(N)) dut (
    .CLK(CLK), .RSTa(RSTa), .Req(Req), .Num_in(Num_in), .Den_in(Den_in),
    .Gnt(Gnt), .Rsp_valid(Rsp_valid), .Rsp_id(Rsp_id), .Rsp_Coc(Rsp_Coc),
    .Rsp_Res(Rsp_Res), .Rsp_ack(Rsp_ack), .Div_Zero(Div_Zero), .Busy(Busy),
    .Div_Start(Div_Start), .Div_Num(Div_Num), .Div_Den(Div_Den),
    .Div_Coc(Div_Coc), .Div_Res(Div_Res), .Div_Done(Div_Done), .dbg_state(dbg_state)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [3:0]  req;
    logic [31:0] num;
    logic [31:0] den;
    logic [1:0]  id;
    logic [31:0] coc;
    logic [31:0] res;
  } vec_t;

  vec_t        vecs[7];
  int          n_cmp = 0, n_err = 0;
  logic [1:0]  exp_q[$];
  int          start_cnt = 0, exp_starts = 0;
  bit          zero_mode;
  logic [3:0]  one = 4'b0001;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Divider stand-in: signed, LAT cycles after Start; result bus is garbage except on Done.
  logic [31:0] m_num, m_den;
  int          m_cnt;
  always @(posedge CLK or negedge RSTa) begin
    if (!RSTa) begin
      m_cnt    <= 0;
      m_num    <= '0;
      m_den    <= '0;
      Div_Done <= 1'b0;
      Div_Coc  <= 32'hDEADBEEF;
      Div_Res  <= 32'hDEADBEEF;
    end else begin
      Div_Done <= 1'b0;
      Div_Coc  <= 32'hDEADBEEF;
      Div_Res  <= 32'hDEADBEEF;
      if (Div_Start) begin
        m_num <= Div_Num;
        m_den <= Div_Den;
        m_cnt <= LAT;
      end else if (m_cnt != 0) begin
        m_cnt <= m_cnt - 1;
        if (m_cnt == 1) begin
          check("div_num_hold", Div_Num, m_num);
          check("div_den_hold", Div_Den, m_den);
          Div_Done <= 1'b1;
          if (m_den == 0) begin
            Div_Coc <= '1;
            Div_Res <= m_num;
          end else begin
            Div_Coc <= $signed(m_num) / $signed(m_den);
            Div_Res <= $signed(m_num) % $signed(m_den);
          end
        end
      end
    end
  end

  // Every Start must find the divider idle.
  always @(negedge CLK) begin
    if (Div_Start) begin
      start_cnt++;
      check("start_overlap", m_cnt, 0);
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic set_lanes(input logic [31:0] num, input logic [31:0] den);
    for (int i = 0; i < N; i++) begin
      Num_in[i*W +: W] = num;
      Den_in[i*W +: W] = den;
    end
  endtask

  task automatic do_reset();
    RSTa = 1'b0; Req = '0; Rsp_ack = 1'b0;
    repeat (3) @(negedge CLK);
    RSTa = 1'b1;
  endtask

  task automatic wait_gnt();
    int n = 0;
    while (Gnt == '0 && n < 60) begin @(negedge CLK); n++; end
  endtask

  task automatic wait_rsp();
    int n = 0;
    while (!Rsp_valid && n < 60) begin @(negedge CLK); n++; end
  endtask

  task automatic ack_pulse();
    Rsp_ack = 1'b1;
    @(negedge CLK);
    Rsp_ack = 1'b0;
  endtask

  task automatic run_txn(input vec_t v);
    int  s0;
    bit  ez;
    ez = zero_mode && (v.den == 0);
    @(negedge CLK);
    Req = v.req;
    set_lanes(v.num, v.den);
    s0 = start_cnt;
    wait_gnt();
    check("gnt", Gnt, one << v.id);
    Req = '0;
    wait_rsp();
    check("rsp_valid", Rsp_valid, 1);
    check("rsp_id", Rsp_id, v.id);
    check("rsp_coc", Rsp_Coc, v.coc);
    check("rsp_res", Rsp_res_w(), v.res);
    check("div_zero", Div_Zero, ez);
    check("starts", start_cnt - s0, ez ? 0 : 1);
    exp_starts += ez ? 0 : 1;
    ack_pulse();
    check("valid_after_ack", Rsp_valid, 0);
    check("busy_after_ack", Busy, 0);
  endtask

  function automatic logic [31:0] Rsp_res_w();
    return Rsp_Res;
  endfunction

  initial begin
    int seen;
`ifdef DIV_ZERO_CHECK_EN
    zero_mode = 1'b1;
`else
    zero_mode = 1'b0;
`endif
    vecs[0] = '{4'b0001, 32'd100,        32'd7,  2'd0, 32'd14,         32'd2};
    vecs[1] = '{4'b0100, 32'hFFFFFFF9,   32'd2,  2'd2, 32'hFFFFFFFD,   32'hFFFFFFFF};
    vecs[2] = '{4'b1000, 32'd1000,       32'd10, 2'd3, 32'd100,        32'd0};
    vecs[3] = '{4'b0011, 32'd9,          32'd4,  2'd0, 32'd2,          32'd1};
    vecs[4] = '{4'b0011, 32'd9,          32'd4,  2'd1, 32'd2,          32'd1};
    vecs[5] = '{4'b1001, 32'h80000000,   32'd3,  2'd3, 32'hD5555556,   32'hFFFFFFFE};
    vecs[6] = '{4'b0010, 32'd55,         32'd0,  2'd1, 32'hFFFFFFFF,   32'd55};

    do_reset();
    #1;
    check("rst_gnt", Gnt, 0);
    check("rst_valid", Rsp_valid, 0);
    check("rst_id", Rsp_id, 0);
    check("rst_coc", Rsp_Coc, 0);
    check("rst_res", Rsp_Res, 0);
    check("rst_zero", Div_Zero, 0);
    check("rst_busy", Busy, 0);
    check("rst_start", Div_Start, 0);
    check("rst_num", Div_Num, 0);
    check("rst_den", Div_Den, 0);

    for (int i = 0; i < 7; i++) run_txn(vecs[i]);

    // Round robin from a fresh reset (pointer was at 2 before it).
    do_reset();
    exp_q.push_back(2'd0); exp_q.push_back(2'd1); exp_q.push_back(2'd2);
    exp_q.push_back(2'd3); exp_q.push_back(2'd0);
    begin
      int s0;
      s0 = start_cnt;
      @(negedge CLK);
      Req = 4'b1111;
      set_lanes(32'd20, 32'd3);
      for (int k = 0; k < 5; k++) begin
        wait_gnt();
        check("rr_gnt", Gnt, one << exp_q.pop_front());
        wait_rsp();
        check("rr_coc", Rsp_Coc, 32'd6);
        check("rr_res", Rsp_Res, 32'd2);
        Rsp_ack = 1'b1;
        @(negedge CLK);
        Rsp_ack = 1'b0;
        if (k == 4) Req = '0;
      end
      repeat (3) @(negedge CLK);
      check("rr_starts", start_cnt - s0, 5);
      exp_starts += 5;
    end

    // Response held without ack while another request waits.
    Req = 4'b0001;
    set_lanes(32'd50, 32'd8);
    wait_gnt();
    check("hold_gnt0", Gnt, 4'b0001);
    Req = '0;
    wait_rsp();
    Req = 4'b0010;
    set_lanes(32'd77, 32'd10);
    for (int k = 0; k < 10; k++) begin
      @(negedge CLK);
      check("hold_valid", Rsp_valid, 1);
      check("hold_coc", Rsp_Coc, 32'd6);
      check("hold_gnt_quiet", Gnt, 0);
    end
    ack_pulse();
    wait_gnt();
    check("hold_gnt1", Gnt, 4'b0010);
    Req = '0;
    wait_rsp();
    check("hold2_id", Rsp_id, 2'd1);
    check("hold2_coc", Rsp_Coc, 32'd7);
    check("hold2_res", Rsp_Res, 32'd7);
    ack_pulse();
    exp_starts += 2;

    // Reset in the middle of WAIT aborts the operation.
    @(negedge CLK);
    Req = 4'b0001;
    set_lanes(32'd100, 32'd7);
    wait_gnt();
    Req = '0;
    repeat (2) @(negedge CLK);
    exp_starts += 1;
    RSTa = 1'b0;
    #1;
    check("abort_busy", Busy, 0);
    check("abort_valid", Rsp_valid, 0);
    check("abort_num", Div_Num, 0);
    check("abort_coc", Rsp_Coc, 0);
    check("abort_start", Div_Start, 0);
    repeat (2) @(negedge CLK);
    Req = 4'b0100;
    set_lanes(32'd12, 32'd5);
    RSTa = 1'b1;
    seen = 0;
    for (int n = 0; n < 60 && Gnt == '0; n++) begin
      @(negedge CLK);
      if (Rsp_valid) seen++;
    end
    check("abort_no_rsp", seen, 0);
    check("abort_gnt", Gnt, 4'b0100);
    Req = '0;
    wait_rsp();
    check("abort2_id", Rsp_id, 2'd2);
    check("abort2_coc", Rsp_Coc, 32'd2);
    check("abort2_res", Rsp_Res, 32'd2);
    ack_pulse();
    exp_starts += 1;

    repeat (3) @(negedge CLK);
    check("total_starts", start_cnt, exp_starts);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
